// File: rtl/pio_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pio_pkg
// Description : Shared types and instruction field positions for the PIO
//               execution sequencer (opcodes, JMP conditions, SET
//               destinations, sequencer FSM states).
// Revision    : 1.0 - initial release
// ============================================================================
package pio_pkg;

    // Instruction word field positions
    localparam int c_OPCODE_MSB   = 15;
    localparam int c_OPCODE_LSB   = 13;
    localparam int c_DELAY_MSB    = 12;
    localparam int c_DELAY_LSB    = 8;
    localparam int c_SEL_MSB      = 7;
    localparam int c_SEL_LSB      = 5;
    localparam int c_INDEX_MSB    = 4;
    localparam int c_INDEX_LSB    = 0;
    localparam int c_WAIT_POL_BIT = 7;
    localparam int c_WAIT_SRC_MSB = 6;
    localparam int c_WAIT_SRC_LSB = 5;
    localparam int c_DELAY_W      = c_DELAY_MSB - c_DELAY_LSB + 1;

    // Opcodes this unit acts on; any other encoding retires as a no-op
    typedef enum logic [2:0] {
        OP_JMP  = 3'b000,
        OP_WAIT = 3'b001,
        OP_SET  = 3'b111
    } opcode_e;

    // JMP condition selector in [7:5]
    typedef enum logic [2:0] {
        JC_ALWAYS  = 3'b000,
        JC_X_ZERO  = 3'b001,
        JC_X_DEC   = 3'b010,
        JC_Y_ZERO  = 3'b011,
        JC_Y_DEC   = 3'b100,
        JC_X_NE_Y  = 3'b101,
        JC_PIN     = 3'b110,
        JC_OSR_NE  = 3'b111
    } jmp_cond_e;

    // SET destination selector in [7:5]; unlisted values are no-ops here
    typedef enum logic [2:0] {
        SD_X = 3'b001,
        SD_Y = 3'b010
    } set_dest_e;

    // Sequencer FSM states
    typedef enum logic [0:0] {
        ST_EXEC  = 1'b0,
        ST_DELAY = 1'b1
    } seq_state_e;

    // A WAIT only tests a GPIO pin when its source field is 00; every other
    // source is serviced elsewhere and counts as already satisfied.
    function automatic logic wait_uses_gpio(input logic [15:0] word);
        return (word[c_WAIT_SRC_MSB:c_WAIT_SRC_LSB] == 2'b00);
    endfunction

endpackage : pio_pkg
`default_nettype wire

// File: rtl/delay_counter.sv
`default_nettype none
// ============================================================================
// Module      : delay_counter
// Description : Instruction delay counter. Loaded with the delay field when
//               a delayed instruction retires, counts down on each enabled
//               cycle and flags expiry on the enabled cycle where it holds 1.
// Revision    : 1.0 - initial release
// ============================================================================
module delay_counter
    import pio_pkg::*;
#(
    parameter int WIDTH = c_DELAY_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             exec_en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic             expire
);

    localparam logic [WIDTH-1:0] c_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] c_ZERO = '0;

    logic [WIDTH-1:0] r_count;

    // Load takes priority; otherwise count down on enabled cycles until zero
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= c_ZERO;
        end else if (load) begin
            r_count <= load_val;
        end else if (exec_en && (r_count != c_ZERO)) begin
            r_count <= r_count - c_ONE;
        end
    end

    assign expire = exec_en && (r_count == c_ONE);

endmodule : delay_counter
`default_nettype wire

// File: rtl/instr_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : instr_sequencer
// Description : Execution sequencer for one PIO state machine. Decodes the
//               instruction at the current PC, evaluates JMP conditions and
//               WAIT stalls, owns the X/Y scratch registers and drives the
//               program counter advance / branch strobes.
//               Build option: PIO_DELAY_EN enables the [12:8] delay field
//               (DELAY state + delay_counter). Without it the field is
//               ignored and every retiring instruction strobes immediately.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_sequencer
    import pio_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              exec_en,
    input  logic [15:0]       instr,
    input  logic [DATA_W-1:0] gpio_in,
    input  logic [4:0]        jmp_pin,
    input  logic              osr_empty,
    output logic              pc_en,
    output logic              jump_en,
    output logic [4:0]        jump,
    output logic              stalled,
    output logic [DATA_W-1:0] x_out,
    output logic [DATA_W-1:0] y_out
);

    localparam logic [DATA_W-1:0] c_XY_ONE  = {{(DATA_W-1){1'b0}}, 1'b1};
    localparam logic [DATA_W-1:0] c_XY_ZERO = '0;

    // ------------------------------------------------------------------
    // Instruction decode
    // ------------------------------------------------------------------
    logic [2:0] w_opcode;
    logic [2:0] w_sel;
    logic [4:0] w_index;
    logic       w_is_jmp;
    logic       w_is_wait;
    logic       w_is_set;
    logic       w_wait_met;
    logic       w_cond_true;
    logic       w_jmp_taken;

    assign w_opcode  = instr[c_OPCODE_MSB:c_OPCODE_LSB];
    assign w_sel     = instr[c_SEL_MSB:c_SEL_LSB];
    assign w_index   = instr[c_INDEX_MSB:c_INDEX_LSB];
    assign w_is_jmp  = (w_opcode == OP_JMP);
    assign w_is_wait = (w_opcode == OP_WAIT);
    assign w_is_set  = (w_opcode == OP_SET);

    assign w_wait_met = !wait_uses_gpio(instr) ||
                        (gpio_in[w_index] == instr[c_WAIT_POL_BIT]);

    // JMP condition, always judged on the X/Y values before any decrement
    always_comb begin
        w_cond_true = 1'b0;
        case (w_sel)
            JC_ALWAYS: w_cond_true = 1'b1;
            JC_X_ZERO: w_cond_true = (x_out == c_XY_ZERO);
            JC_X_DEC:  w_cond_true = (x_out != c_XY_ZERO);
            JC_Y_ZERO: w_cond_true = (y_out == c_XY_ZERO);
            JC_Y_DEC:  w_cond_true = (y_out != c_XY_ZERO);
            JC_X_NE_Y: w_cond_true = (x_out != y_out);
            JC_PIN:    w_cond_true = gpio_in[jmp_pin];
            JC_OSR_NE: w_cond_true = !osr_empty;
            default:   w_cond_true = 1'b0;
        endcase
    end

    assign w_jmp_taken = w_is_jmp && w_cond_true;

    // ------------------------------------------------------------------
    // Retire / stall qualification
    // ------------------------------------------------------------------
    logic w_in_exec;
    logic w_retire;
    logic w_pc_en_raw;
    logic w_jump_en_raw;
    logic [4:0] w_jump_raw;

    assign w_retire = w_in_exec && exec_en && (!w_is_wait || w_wait_met);

`ifdef PIO_DELAY_EN
    // ------------------------------------------------------------------
    // Delayed-retire path: the strobe is held back by the delay field
    // ------------------------------------------------------------------
    seq_state_e r_state;
    logic       r_taken;
    logic [4:0] r_target;
    logic [c_DELAY_W-1:0] w_delay;
    logic       w_load;
    logic       w_exec_strobe;
    logic       w_expire;

    assign w_in_exec     = (r_state == ST_EXEC);
    assign w_delay       = instr[c_DELAY_MSB:c_DELAY_LSB];
    assign w_load        = w_retire && (w_delay != '0);
    assign w_exec_strobe = w_retire && (w_delay == '0);

    delay_counter #(
        .WIDTH (c_DELAY_W)
    ) u_delay_counter (
        .clk      (clk),
        .rst      (rst),
        .exec_en  (exec_en),
        .load     (w_load),
        .load_val (w_delay),
        .expire   (w_expire)
    );

    // EXEC/DELAY sequencing; the branch decision is captured at retire so
    // instr can change freely while the delay runs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ST_EXEC;
            r_taken  <= 1'b0;
            r_target <= 5'd0;
        end else begin
            case (r_state)
                ST_EXEC: begin
                    if (w_load) begin
                        r_state  <= ST_DELAY;
                        r_taken  <= w_jmp_taken;
                        r_target <= w_index;
                    end
                end
                ST_DELAY: begin
                    if (w_expire) begin
                        r_state <= ST_EXEC;
                    end
                end
                default: r_state <= ST_EXEC;
            endcase
        end
    end

    assign w_pc_en_raw   = w_exec_strobe || (!w_in_exec && w_expire);
    assign w_jump_en_raw = (w_exec_strobe && w_jmp_taken) ||
                           (!w_in_exec && w_expire && r_taken);
    assign w_jump_raw    = w_in_exec ? w_index : r_target;
`else
    // ------------------------------------------------------------------
    // No delay support: [12:8] is reserved and every retire strobes at once
    // ------------------------------------------------------------------
    logic w_unused_delay_field;

    assign w_unused_delay_field = ^instr[c_DELAY_MSB:c_DELAY_LSB];
    assign w_in_exec     = 1'b1;
    assign w_pc_en_raw   = w_retire;
    assign w_jump_en_raw = w_retire && w_jmp_taken;
    assign w_jump_raw    = w_index;
`endif

    // ------------------------------------------------------------------
    // Scratch registers: side effects land once, on the retire cycle
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] r_x;
    logic [DATA_W-1:0] r_y;
    logic [DATA_W-1:0] w_set_value;

    assign w_set_value = {{(DATA_W-5){1'b0}}, w_index};

    // X/Y update from SET and from the decrementing JMP conditions
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_x <= c_XY_ZERO;
            r_y <= c_XY_ZERO;
        end else if (w_retire) begin
            if (w_is_jmp && (w_sel == JC_X_DEC)) begin
                r_x <= r_x - c_XY_ONE;
            end
            if (w_is_jmp && (w_sel == JC_Y_DEC)) begin
                r_y <= r_y - c_XY_ONE;
            end
            if (w_is_set && (w_sel == SD_X)) begin
                r_x <= w_set_value;
            end
            if (w_is_set && (w_sel == SD_Y)) begin
                r_y <= w_set_value;
            end
        end
    end

    assign x_out = r_x;
    assign y_out = r_y;

    // ------------------------------------------------------------------
    // Outputs: all strobes are quiet while reset is held
    // ------------------------------------------------------------------
    assign pc_en   = !rst && w_pc_en_raw;
    assign jump_en = !rst && w_jump_en_raw;
    assign jump    = rst ? 5'd0 : w_jump_raw;
    assign stalled = !rst && w_in_exec && exec_en && w_is_wait && !w_wait_met;

endmodule : instr_sequencer
`default_nettype wire

// File: doc/instr_sequencer.md
# instr_sequencer

Execution sequencer for one PIO state machine; sits directly upstream of `program_counter`. Each cycle it decodes the instruction word fetched at the current PC and evaluates JMP conditions and WAIT stalls. It owns the X/Y scratch registers and the instruction delay counter. It drives `pc_en`, `jump_en` and `jump` so the program counter advances, branches or holds on the correct cycle. Opcodes other than JMP, WAIT and SET are retired as single-cycle no-ops here; their data-path effects belong to other units.

## Interface
- `DATA_W`, default 32: width of X, Y and GPIO.
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- exec_en  in  1  clock-divider tick; when low the block is frozen
- instr  in  16  instruction at the current PC, combinationally valid from the instruction memory
- gpio_in  in  DATA_W  synchronised pin values
- jmp_pin  in  5  pin index for the JMP PIN condition
- osr_empty  in  1  output shift register empty flag
- pc_en  out  1  PC advance strobe (combinational)
- jump_en  out  1  load `jump` into PC (combinational, only with `pc_en`)
- jump  out  5  branch target
- stalled  out  1  WAIT condition unmet this cycle
- x_out, y_out  out  DATA_W  scratch register values

## Operation
- Instruction fields: [15:13] opcode (JMP=000, WAIT=001, SET=111, others treated as NOP); [12:8] delay; [7:0] argument.
- FSM states: EXEC and DELAY. Reset state is EXEC.
- EXEC with `exec_en` high: decode `instr` and compute `retire`.
  - JMP, SET and NOP always retire.
  - WAIT retires only when `gpio_in[instr[4:0]] == instr[7]`. Source field [6:5] values other than 00 are treated as always met. While unmet: `stalled`=1, `pc_en`=0, no state change.
- JMP conditions, by [7:5]. All are evaluated on pre-update X/Y.
  - 000: always.
  - 001: X==0.
  - 010: X!=0, then X decrements.
  - 011: Y==0.
  - 100: Y!=0, then Y decrements.
  - 101: X!=Y.
  - 110: `gpio_in[jmp_pin]`.
  - 111: !`osr_empty`.
- Decrement wraps: X==0 under cond 010 gives X=all-ones and no jump.
- SET destinations by [7:5]: 001 writes X, 010 writes Y. Both zero-extend [4:0]. Other destinations are no-ops.
- Side effects (SET, X--/Y--) happen once, on the retire cycle in EXEC.
- On retire with delay==0: `pc_en`=1 that cycle; `jump_en`/`jump` = taken / [4:0].
- On retire with delay d>0:
  - Register the taken flag and target.
  - Load the counter with d; `pc_en`=0; go to DELAY.
- DELAY: on each `exec_en` the counter decrements. When the counter is 1 and `exec_en` is high:
  - `pc_en`=1 with the registered jump; return to EXEC.
  - `instr` is ignored while in DELAY.
- `exec_en` low: outputs `pc_en`/`jump_en`=0, `stalled`=0; registers and state hold.

## Timing
- Reset values: state EXEC, X=0, Y=0, delay counter 0, registered jump 0; `pc_en`=`jump_en`=`stalled`=0, `jump`=0.
- `pc_en`, `jump_en`, `jump` and `stalled` are forced to 0 while `rst` is high.
- Latency of an instruction with delay d: d+1 enabled cycles from entering EXEC to the `pc_en` strobe. The PC updates on the following clock edge.
- X/Y updates are visible on `x_out`/`y_out` the cycle after retire.
- Reset mid-DELAY: the pending jump is discarded; the block resumes in EXEC.
- `jump_en` is never asserted without `pc_en`.

## Configuration
- Macro `PIO_DELAY_EN`.
- Defined: delay field honoured as described above.
- Undefined: [12:8] is ignored. There is no DELAY state or counter, and every retiring instruction strobes `pc_en` on its EXEC cycle. This frees [12:8] for a future side-set unit.

## Structure
- `pio_pkg` holds: the opcode enum, the JMP-condition enum, the SET-destination enum, the FSM state enum, and the field-position localparams.
- One sub-module, `delay_counter`, holds the load/decrement/expire logic. It is instantiated only under `PIO_DELAY_EN`.

## Test plan
- After reset, `instr`=0x0000 (JMP always 0), `exec_en`=1: `pc_en`=1, `jump_en`=1, `jump`=0 every cycle.
- SET X=5 (0xE025), then repeated JMP X-- to 3 (0x0043): `jump_en` high on 5 consecutive retires with X going 4,3,2,1,0. The 6th retire has `jump_en`=0 and X=0xFFFFFFFF.
- WAIT 1 on pin 7 (0x2087) with `gpio_in[7]`=0 for 4 cycles: `stalled`=1 and `pc_en`=0 for 4 cycles. `pc_en`=1 on the cycle the pin rises.
- JMP always to 9 with delay 3 (0x0309): `pc_en`=0 for 3 cycles, then `pc_en`=1 with `jump`=9. Without `PIO_DELAY_EN`, the strobe comes immediately.
- Same delayed JMP with `exec_en` toggling every other cycle: the strobe arrives on the 4th enabled cycle.
- Assert `rst` in the 2nd DELAY cycle: all outputs 0, X/Y cleared. After release, the first `pc_en` follows the current `instr` with no pending jump.
